// File: rtl/alu_serial_pkg.sv
// Shared constants for the bit-serial ALU: op codes, control bit positions
// and FSM state encoding.
package alu_serial_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    localparam int CTRL_INVA = 3;
    localparam int CTRL_INVB = 2;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/Full_adder.sv
// One-bit full adder shared by the ripple and serial ALU slices.
module Full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum and majority carry.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/alu_serial_slice.sv
// Combinational one-bit ALU stage: optional operand inversion, then AND, OR
// or full-add depending on op. SLT produces the adder sum here; the set bit
// is formed by the sequencer at the MSB.
module alu_serial_slice
    import alu_serial_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       invertA,
    input  logic       invertB,
    input  logic       carryIn,
    input  logic [1:0] op,
    output logic       bit_out,
    output logic       carryOut
);

    logic a_eff;
    logic b_eff;
    logic fa_sum;
    logic fa_cout;

    assign a_eff = a ^ invertA;
    assign b_eff = b ^ invertB;

    Full_adder u_fa (
        .a    (a_eff),
        .b    (b_eff),
        .cin  (carryIn),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Select the bit function; carry is only meaningful for ADD/SLT.
    always_comb begin
        bit_out  = fa_sum;
        carryOut = fa_cout;
        case (op)
            OP_AND:  begin bit_out = a_eff & b_eff; carryOut = 1'b0; end
            OP_OR:   begin bit_out = a_eff | b_eff; carryOut = 1'b0; end
            default: begin bit_out = fa_sum;        carryOut = fa_cout; end
        endcase
    end

endmodule

// File: rtl/alu_bit_serial.sv
// Bit-serial ALU: one operand bit per clock, LSB first, through a single
// registered carry. Flags are formed at the MSB step and published together
// with the result in the DONE cycle.
module alu_bit_serial
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ALU_control_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic             slice_bit;
    logic             slice_cout;
    logic             last_step;
    logic             arith;
    logic             set_bit;

    alu_serial_slice u_slice (
        .a        (a_q[cnt_q]),
        .b        (b_q[cnt_q]),
        .invertA  (ctrl_q[CTRL_INVA]),
        .invertB  (ctrl_q[CTRL_INVB]),
        .carryIn  (carry_q),
        .op       (ctrl_q[1:0]),
        .bit_out  (slice_bit),
        .carryOut (slice_cout)
    );

    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
    assign arith     = ctrl_q[1];
    // At the MSB step carry_q is the carry into the MSB.
    assign set_bit   = slice_bit ^ (carry_q ^ slice_cout);

    // Sequencer: latch on start, shift one bit per RUN cycle, publish at MSB.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        ctrl_d   = ctrl_q;
        sr_d     = sr_q;
        result_d = result_q;
        zero_d   = zero_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_d     = src1_i;
                    b_d     = src2_i;
                    ctrl_d  = ALU_control_i;
                    cnt_d   = '0;
                    // Subtraction is A + ~B + 1, so the carry-in equals invertB.
                    carry_d = ALU_control_i[CTRL_INVB];
                    sr_d    = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sr_d    = {slice_bit, sr_q[WIDTH-1:1]};
                carry_d = slice_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_step) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    result_d = (ctrl_q[1:0] == OP_SLT) ? {{(WIDTH-1){1'b0}}, set_bit} : sr_d;
                    zero_d   = (result_d == '0);
                    cout_d   = arith & slice_cout;
                    ovf_d    = arith & (carry_q ^ slice_cout);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything, aborting any op.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            sr_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctrl_q   <= ctrl_d;
            sr_q     <= sr_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy_o     = (state_q == ST_RUN);
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign zero_o     = zero_q;
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_alu_bit_serial.sv
// Bench for alu_bit_serial: directed and random ops, scoreboard of expected
// results from an arithmetic reference model, checked by a done_o monitor.
module tb_alu_bit_serial;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] src1 = '0;
    logic [W-1:0] src2 = '0;
    logic [3:0]   ctrl = '0;
    logic         busy_o, done_o, zero_o, cout_o, overflow_o;
    logic [W-1:0] result_o;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_done_cyc = 0;
    exp_t sb[$];

    alu_bit_serial #(.WIDTH(W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .src1_i        (src1),
        .src2_i        (src2),
        .ALU_control_i (ctrl),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .result_o      (result_o),
        .zero_o        (zero_o),
        .cout_o        (cout_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
        logic [W-1:0] ap, bp;
        logic [W:0]   s;
        logic         ov;
        exp_t         e;
        ap = c[3] ? ~a : a;
        bp = c[2] ? ~b : b;
        s  = {1'b0, ap} + {1'b0, bp} + {{W{1'b0}}, c[2]};
        ov = (ap[W-1] == bp[W-1]) && (s[W-1] != ap[W-1]);
        case (c[1:0])
            2'b00:   begin e.res = ap & bp; e.c = 1'b0; e.v = 1'b0; end
            2'b01:   begin e.res = ap | bp; e.c = 1'b0; e.v = 1'b0; end
            2'b10:   begin e.res = s[W-1:0]; e.c = s[W]; e.v = ov; end
            default: begin e.res = {{(W-1){1'b0}}, s[W-1] ^ ov}; e.c = s[W]; e.v = ov; end
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every done_o pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done_o) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result",   64'(result_o),   64'(e.res));
                check("zero",     64'(zero_o),     64'(e.z));
                check("cout",     64'(cout_o),     64'(e.c));
                check("overflow", 64'(overflow_o), 64'(e.v));
            end
        end
    end

    // Present one request in an IDLE cycle; accepted at the next rising edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c, input bit expect_done);
        @(posedge clk); #1;
        src1 = a; src2 = b; ctrl = c; start = 1'b1;
        if (expect_done) sb.push_back(model(a, b, c));
        @(posedge clk); #1;
        start = 1'b0;
        src1 = $urandom; src2 = $urandom; ctrl = 4'($urandom);
    endtask

    // Wait for done_o, checking latency and busy length; optionally pulse start mid-op.
    task automatic wait_done(input bit pulse);
        int n;
        int nb;
        n = 0;
        nb = 0;
        for (int k = 1; k <= 3 * W; k++) begin
            @(negedge clk);
            if (busy_o) nb++;
            if (pulse) begin
                start = (k == 5) || (k == W + 1);
                if (start) begin src1 = $urandom; src2 = $urandom; ctrl = 4'($urandom); end
            end
            if (done_o) begin
                n = k;
                last_done_cyc = cyc;
                break;
            end
        end
        if (pulse) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("done_latency", 64'(n), 64'(W + 1));
        check("busy_cycles", 64'(nb), 64'(W));
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_busy"}, 64'(busy_o), 64'd0);
        check({nm, "_done"}, 64'(done_o), 64'd0);
        check({nm, "_result"}, 64'(result_o), 64'd0);
        check({nm, "_flags"}, 64'({zero_o, cout_o, overflow_o}), 64'd0);
    endtask

    initial begin
        int d1;
        int dones;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        issue(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 1'b1); wait_done(1'b0);
        issue(32'd5, 32'd5, 4'b0110, 1'b1);                 wait_done(1'b0);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 4'b0111, 1'b1); wait_done(1'b0);
        issue(32'h8000_0000, 32'h0000_0001, 4'b0111, 1'b1); wait_done(1'b0);
        issue(32'h0000_0003, 32'h0000_0002, 4'b0111, 1'b1); wait_done(1'b0);
        issue(32'h0F0F_0F0F, 32'h00FF_00FF, 4'b1100, 1'b1); wait_done(1'b0);

        // Stray starts during RUN and DONE must not queue a second op.
        issue(32'd1, 32'd2, 4'b0010, 1'b1); wait_done(1'b1);
        repeat (W + 4) @(negedge clk);
        check("no_extra_busy", 64'(busy_o), 64'd0);

        // Reset ten cycles into an op aborts it with all outputs cleared.
        issue(32'h1234_5678, 32'h1111_1111, 4'b0010, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midreset");
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 2 * W; k++) begin
            @(negedge clk);
            if (done_o || busy_o) dones++;
        end
        check("aborted_no_done", 64'(dones), 64'd0);

        // Back-to-back ops, second started in the first IDLE cycle.
        issue(32'd1, 32'd2, 4'b0010, 1'b1); wait_done(1'b0);
        d1 = last_done_cyc;
        issue(32'h0000_00A0, 32'h0000_0005, 4'b0001, 1'b1); wait_done(1'b0);
        check("done_spacing", 64'(last_done_cyc - d1), 64'(W + 2));

        for (int t = 0; t < 40; t++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = (t % 4 == 0) ? a : W'($urandom);
            issue(a, b, 4'($urandom), 1'b1);
            wait_done(1'b0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
